// File: rtl/result_bcd_conv_pkg.sv
// Shared constants for the ALU result to BCD converter: digit counts,
// iteration count, digit width and the controller state encoding.
package result_bcd_conv_pkg;

  localparam int DIGITS  = 5;
  localparam int ITERS   = 17;
  localparam int DIGIT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/result_bcd_conv_if.sv
// Request/result bundle between the ALU side and the BCD converter.
interface result_bcd_conv_if #(
  parameter int DIGITS = result_bcd_conv_pkg::DIGITS
);

  logic                  start;
  logic [7:0]            result_lo;
  logic [7:0]            result_hi;
  logic                  carry;
  logic                  overflow;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  err;

  modport master (
    output start, result_lo, result_hi, carry, overflow,
    input  busy, done, bcd, err
  );

  modport slave (
    input  start, result_lo, result_hi, carry, overflow,
    output busy, done, bcd, err
  );

endinterface

// File: rtl/result_bcd_conv_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import result_bcd_conv_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  // Add 3 only when the digit would overflow past 9 after doubling
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/result_bcd_conv.sv
// Converts the combined ALU result {hi,lo} + carry*256 into packed BCD using
// one double-dabble iteration per clock; an overflowed result short-circuits
// straight to an error report.
module result_bcd_conv
  import result_bcd_conv_pkg::*;
#(
  parameter int DIGITS = result_bcd_conv_pkg::DIGITS,
  parameter int ITERS  = result_bcd_conv_pkg::ITERS
) (
  input  logic               clk,
  input  logic               reset,
  result_bcd_conv_if.slave   conv
);

  localparam int         WORK_W    = DIGIT_W * DIGITS;
  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  logic [1:0]              state;
  logic [ITERS-1:0]        value;
  logic [WORK_W-1:0]       work;
  logic [4:0]              count;
  logic [WORK_W-1:0]       bcd_q;
  logic                    err_q;

  logic [ITERS-1:0]        value_in;
  logic [WORK_W-1:0]       adj;
  logic [WORK_W+ITERS-1:0] shifted;
  logic [WORK_W-1:0]       work_next;
  logic [ITERS-1:0]        value_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (work[g*DIGIT_W +: DIGIT_W]),
      .adjusted (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Combined input value and the next double-dabble step of {work,value}
  always_comb begin
    value_in   = ITERS'({conv.result_hi, conv.result_lo}) + ITERS'({conv.carry, 8'h00});
    shifted    = {adj, value} << 1;
    work_next  = shifted[WORK_W+ITERS-1:ITERS];
    value_next = shifted[ITERS-1:0];
  end

  // Controller: accept in IDLE/DONE, iterate in SHIFT, report for one cycle in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      value <= '0;
      work  <= '0;
      count <= '0;
      bcd_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          value <= value_next;
          work  <= work_next;
          count <= count + 5'd1;
          if (count == LAST_ITER) begin
            state <= ST_DONE;
            bcd_q <= work_next;
            err_q <= 1'b0;
          end
        end
        default: begin
          if (conv.start) begin
            if (conv.overflow) begin
              state <= ST_DONE;
              bcd_q <= '0;
              err_q <= 1'b1;
            end else begin
              state <= ST_SHIFT;
              value <= value_in;
              work  <= '0;
              count <= '0;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign conv.busy = (state == ST_SHIFT);
  assign conv.done = (state == ST_DONE);
  assign conv.bcd  = bcd_q;
  assign conv.err  = err_q;

endmodule

// File: tb/tb_result_bcd_conv.sv
// Bench for result_bcd_conv: fixed vectors, randomized conversions against a
// decimal reference model, and hand-written abort / ignore / re-accept sequences.
module tb_result_bcd_conv;

  logic clk = 1'b0;
  logic reset;

  result_bcd_conv_if conv ();

  result_bcd_conv dut (
    .clk   (clk),
    .reset (reset),
    .conv  (conv)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        carry;
    logic        ovf;
    logic [19:0] exp_bcd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Decimal digits of the value computed with plain arithmetic
  function automatic logic [19:0] refBcd(input int unsigned v);
    logic [19:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [7:0] lo, input logic [7:0] hi, input logic c, input logic o);
    conv.result_lo = lo;
    conv.result_hi = hi;
    conv.carry     = c;
    conv.overflow  = o;
    conv.start     = 1'b1;
  endtask

  // One full request: returns the observed result, latency in cycles and busy cycles
  task automatic runConv(input logic [7:0] lo, input logic [7:0] hi, input logic c, input logic o,
                         input bit scramble, output logic [19:0] got_bcd, output logic got_err,
                         output int lat, output int busy_cnt);
    @(posedge clk); #1;
    applyStimulus(lo, hi, c, o);
    @(posedge clk); #1;
    conv.start = 1'b0;
    if (scramble) begin
      conv.result_lo = 8'($urandom);
      conv.result_hi = 8'($urandom);
      conv.carry     = 1'($urandom);
      conv.overflow  = 1'($urandom);
    end
    lat      = 0;
    busy_cnt = 0;
    got_bcd  = 'x;
    got_err  = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (conv.busy) busy_cnt++;
      if (conv.done) begin
        lat     = k;
        got_bcd = conv.bcd;
        got_err = conv.err;
        break;
      end
    end
  endtask

  // Check one conversion plus the cycle after it (pulse width and hold)
  task automatic checkConv(input string tag, input logic [19:0] exp_bcd, input logic exp_err, input int exp_lat,
                           input logic [19:0] got_bcd, input logic got_err, input int lat, input int busy_cnt);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_bcd"}, 32'(got_bcd), 32'(exp_bcd));
    checkOutput({tag, "_err"}, 32'(got_err), 32'(exp_err));
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    @(negedge clk);
    checkOutput({tag, "_done_width"}, 32'(conv.done), 32'd0);
    checkOutput({tag, "_bcd_hold"}, 32'(conv.bcd), 32'(exp_bcd));
  endtask

  initial begin
    logic [19:0] got_bcd;
    logic        got_err;
    int          lat;
    int          busy_cnt;
    int          done_cnt;
    logic [19:0] first_bcd;
    logic        first_err;
    logic [7:0]  rlo;
    logic [7:0]  rhi;
    logic        rc;
    logic        ro;
    logic [19:0] exp_bcd;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 20'h00000, 1'b0, 18};
    vecs[1] = '{8'h2C, 8'h00, 1'b1, 1'b0, 20'h00300, 1'b0, 18};
    vecs[2] = '{8'h01, 8'hFE, 1'b0, 1'b0, 20'h65025, 1'b0, 18};
    vecs[3] = '{8'h80, 8'h00, 1'b0, 1'b1, 20'h00000, 1'b1, 1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 20'h65791, 1'b0, 18};
    vecs[5] = '{8'hE7, 8'h03, 1'b1, 1'b0, 20'h01255, 1'b0, 18};

    conv.start     = 1'b0;
    conv.result_lo = '0;
    conv.result_hi = '0;
    conv.carry     = 1'b0;
    conv.overflow  = 1'b0;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 32'(conv.busy), 32'd0);
    checkOutput("reset_done", 32'(conv.done), 32'd0);
    checkOutput("reset_bcd", 32'(conv.bcd), 32'd0);
    checkOutput("reset_err", 32'(conv.err), 32'd0);

    for (int i = 0; i < 6; i++) begin
      runConv(vecs[i].lo, vecs[i].hi, vecs[i].carry, vecs[i].ovf, 1'b0, got_bcd, got_err, lat, busy_cnt);
      checkConv($sformatf("vec%0d", i), vecs[i].exp_bcd, vecs[i].exp_err, vecs[i].exp_lat,
                got_bcd, got_err, lat, busy_cnt);
    end

    for (int i = 0; i < 25; i++) begin
      rlo = 8'($urandom);
      rhi = 8'($urandom);
      rc  = 1'($urandom);
      ro  = ($urandom_range(0, 6) == 0);
      exp_bcd = ro ? 20'h0 : refBcd(int'({rhi, rlo}) + (rc ? 256 : 0));
      runConv(rlo, rhi, rc, ro, 1'b1, got_bcd, got_err, lat, busy_cnt);
      checkConv($sformatf("rand%0d", i), exp_bcd, ro, ro ? 1 : 18, got_bcd, got_err, lat, busy_cnt);
    end

    // Accept a new request while in DONE: overflow request straight back to DONE
    runConv(8'h39, 8'h30, 1'b0, 1'b0, 1'b0, got_bcd, got_err, lat, busy_cnt);
    checkOutput("b2b_first_bcd", 32'(got_bcd), 32'h12345);
    applyStimulus(8'h11, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    conv.start    = 1'b0;
    conv.overflow = 1'b0;
    @(negedge clk);
    checkOutput("b2b_done", 32'(conv.done), 32'd1);
    checkOutput("b2b_err", 32'(conv.err), 32'd1);
    checkOutput("b2b_bcd", 32'(conv.bcd), 32'd0);

    // Start during SHIFT cycle 5 must be ignored
    @(posedge clk); #1;
    applyStimulus(8'h0A, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    conv.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    applyStimulus(8'h63, 8'h01, 1'b1, 1'b1);
    @(posedge clk); #1;
    conv.start    = 1'b0;
    conv.overflow = 1'b0;
    done_cnt  = 0;
    first_bcd = 'x;
    first_err = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (conv.done) begin
        if (done_cnt == 0) begin
          first_bcd = conv.bcd;
          first_err = conv.err;
        end
        done_cnt++;
      end
    end
    checkOutput("ignore_done_count", 32'(done_cnt), 32'd1);
    checkOutput("ignore_bcd", 32'(first_bcd), 32'h00010);
    checkOutput("ignore_err", 32'(first_err), 32'd0);

    // Reset during SHIFT cycle 10 aborts with no done pulse
    @(posedge clk); #1;
    applyStimulus(8'h34, 8'h12, 1'b0, 1'b0);
    @(posedge clk); #1;
    conv.start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(conv.busy), 32'd0);
    checkOutput("abort_done", 32'(conv.done), 32'd0);
    checkOutput("abort_bcd", 32'(conv.bcd), 32'd0);
    checkOutput("abort_err", 32'(conv.err), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (conv.done) done_cnt++;
    end
    checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
    runConv(8'h7B, 8'h00, 1'b0, 1'b0, 1'b0, got_bcd, got_err, lat, busy_cnt);
    checkConv("after_abort", 20'h00123, 1'b0, 18, got_bcd, got_err, lat, busy_cnt);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/result_bcd_conv.md
RESULT_BCD_CONV -- requirements
Module: result_bcd_conv

Interface
REQ-001 Parameter DIGITS, default 5, number of BCD output digits.
REQ-002 Parameter ITERS, default 17, shift iterations (width of the combined binary value).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  request to convert the present ALU result; sampled only in IDLE or DONE.
REQ-006 result_lo  input  8  ALU main output (out).
REQ-007 result_hi  input  8  ALU extended output (extended_out).
REQ-008 carry  input  1  ALU carry flag.
REQ-009 overflow  input  1  ALU overflow flag.
REQ-010 busy  output  1  high while a conversion is in progress.
REQ-011 done  output  1  one-cycle pulse marking a new valid bcd/err.
REQ-012 bcd  output  4*DIGITS  packed BCD; digit 0 in bits [3:0].
REQ-013 err  output  1  last accepted request had overflow set.

Function
REQ-014 States: IDLE, SHIFT, DONE; the encoding shall come from the shared package.
REQ-015 IDLE or DONE, start=1, overflow=0: latch value = {result_hi,result_lo} + (carry<<8) as a 17-bit unsigned number, clear the BCD work register and the iteration counter, then go to SHIFT.
REQ-016 IDLE or DONE, start=1, overflow=1: go directly to DONE on the next edge with bcd=0 and err=1, with no SHIFT cycles.
REQ-017 SHIFT: one double-dabble iteration per cycle: every digit >=5 gets +3, then {work,value} shifts left by one bit.
REQ-018 SHIFT lasts exactly ITERS cycles; after the last iteration go to DONE.
REQ-019 On entry to DONE, load bcd from the work register (or 0 on the overflow path) and set err accordingly.
REQ-020 DONE lasts one cycle: done=1, busy=0; then IDLE unless start=1, in which case REQ-015/016 apply.
REQ-021 busy=1 exactly in SHIFT.
REQ-022 start in SHIFT is ignored and not queued.
REQ-023 Latency from start-sampling edge to done=1: ITERS+1 cycles (18) on the normal path, 1 cycle on the overflow path.
REQ-024 bcd and err hold their last values from the end of DONE until the next DONE.
REQ-025 Maximum input 65791 fits in 5 digits; no digit shall ever exceed 9.
REQ-026 Inputs are sampled only at the accept edge; changes during SHIFT have no effect.

Reset
REQ-027 reset=1 at a clock edge forces IDLE, busy=0, done=0, bcd=0, err=0, counter=0, work register=0.
REQ-028 reset takes priority over start and aborts any conversion in progress; no done pulse is produced for an aborted conversion.

Structure
REQ-029 The shared package shall hold DIGITS, ITERS, the state enumeration, and the BCD digit width (4).
REQ-030 One combinational sub-module, bcd_add3: 4-bit in, 4-bit out, +3 when input >=5; instantiated DIGITS times.
REQ-031 The iteration counter shall be 5 bits wide and saturate-free, compared against ITERS-1.

Verification
REQ-032 Zero: lo=0x00, hi=0x00, carry=0, start -> done at +18 cycles, bcd=0x00000, err=0.
REQ-033 Add with carry (200+100): lo=0x2C, hi=0x00, carry=1 -> bcd=0x00300, err=0.
REQ-034 Multiply max (255*255): hi=0xFE, lo=0x01 -> bcd=0x65025, busy high 17 cycles.
REQ-035 Overflow: overflow=1, lo=0x80 -> done at +1 cycle, bcd=0x00000, err=1.
REQ-036 Start pulsed at cycle 5 of SHIFT with different inputs -> ignored; the first result is reported, with exactly one done pulse.
REQ-037 Reset asserted at SHIFT cycle 10 -> next cycle IDLE, all outputs 0, no done; a fresh start with lo=0x7B (123) -> bcd=0x00123.
